// File: rtl/VX_ag_tcu_pkg.sv
// Shared AG-TCU definitions: PE index constants and the PE select field type.
package VX_ag_tcu_pkg;

  localparam int AG_TCU_PE_FP    = 0;
  localparam int AG_TCU_PE_INT   = 1;
  localparam int AG_TCU_PE_COUNT = 2;
  localparam int AG_TCU_PE_SEL_W = $clog2(AG_TCU_PE_COUNT);

  typedef logic [AG_TCU_PE_SEL_W-1:0] ag_tcu_pe_sel_t;

endpackage

// File: rtl/ag_tcu_order_fifo.sv
// Synchronous FIFO with wrap-bit pointers; push while full and pop while empty are ignored.
module ag_tcu_order_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop_data = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/ag_tcu_pe_arb.sv
// Steers execute requests to PEs under per-PE credit limits and retires PE
// responses strictly in issue order through one registered response port.
module ag_tcu_pe_arb
  import VX_ag_tcu_pkg::*;
#(
  parameter int PE_COUNT        = AG_TCU_PE_COUNT,
  parameter int DATAW           = 64,
  parameter int TAG_W           = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ORDER_DEPTH     = 8,
  localparam int PE_SEL_W       = $clog2(PE_COUNT)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [PE_SEL_W-1:0]       req_pe_sel,
  input  logic [TAG_W-1:0]          req_tag,
  output logic [PE_COUNT-1:0]       pe_req_valid,
  input  logic [PE_COUNT-1:0]       pe_req_ready,
  output logic [TAG_W-1:0]          pe_req_tag,
  input  logic [PE_COUNT-1:0]       pe_rsp_valid,
  output logic [PE_COUNT-1:0]       pe_rsp_ready,
  input  logic [PE_COUNT*TAG_W-1:0] pe_rsp_tag,
  input  logic [PE_COUNT*DATAW-1:0] pe_rsp_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [TAG_W-1:0]          rsp_tag,
  output logic [DATAW-1:0]          rsp_data,
  output logic [PE_SEL_W-1:0]       rsp_pe,
  output logic                      busy
);

  // Handshakes: a transfer happens on any edge where valid & ready are both 1;
  // ready never depends on valid, and a valid source holds its payload until taken.

  localparam int CRED_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PE_SEL_W:0]   SEL_LIMIT = (PE_SEL_W+1)'(PE_COUNT);
  localparam logic [CRED_W-1:0]   CRED_MAX  = CRED_W'(MAX_OUTSTANDING);

  logic [CRED_W-1:0]   credit [PE_COUNT];
  logic [PE_SEL_W-1:0] head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                sel_in_range;
  logic                sel_ok;
  logic                issue_fire;
  logic                rsp_fire;
  logic                out_free;
  logic [PE_COUNT-1:0] inc;
  logic [PE_COUNT-1:0] dec;

  assign pe_req_tag = req_tag;
  assign busy       = !fifo_empty || rsp_valid;

  always_comb begin
    pe_req_valid = '0;
    pe_rsp_ready = '0;
    req_ready    = 1'b0;
    sel_in_range = ({1'b0, req_pe_sel} < SEL_LIMIT);
    sel_ok       = 1'b0;
    if (sel_in_range) begin
      sel_ok                   = !fifo_full && (credit[req_pe_sel] < CRED_MAX);
      pe_req_valid[req_pe_sel] = req_valid && sel_ok;
      req_ready                = sel_ok && pe_req_ready[req_pe_sel];
    end
    issue_fire = req_valid && req_ready;
    out_free   = !rsp_valid || rsp_ready;
    // Only the oldest outstanding PE may hand back a response; a zero credit blocks it.
    if (!fifo_empty) pe_rsp_ready[head] = out_free && (credit[head] != '0);
    rsp_fire = |(pe_rsp_valid & pe_rsp_ready);
    for (int i = 0; i < PE_COUNT; i++) begin
      inc[i] = issue_fire && (req_pe_sel == PE_SEL_W'(i));
      dec[i] = rsp_fire && (head == PE_SEL_W'(i));
    end
  end

  ag_tcu_order_fifo #(
    .WIDTH (PE_SEL_W),
    .DEPTH (ORDER_DEPTH)
  ) u_order_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (issue_fire),
    .push_data (req_pe_sel),
    .pop       (rsp_fire),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PE_COUNT; i++) credit[i] <= '0;
    end else begin
      for (int i = 0; i < PE_COUNT; i++) begin
        if (inc[i] && !dec[i])      credit[i] <= credit[i] + CRED_W'(1);
        else if (dec[i] && !inc[i]) credit[i] <= credit[i] - CRED_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_tag   <= '0;
      rsp_data  <= '0;
      rsp_pe    <= '0;
    end else if (rsp_fire) begin
      rsp_valid <= 1'b1;
      rsp_tag   <= pe_rsp_tag[int'(head)*TAG_W +: TAG_W];
      rsp_data  <= pe_rsp_data[int'(head)*DATAW +: DATAW];
      rsp_pe    <= head;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  sel_range_a: assert property (@(posedge clk) disable iff (!reset)
    req_valid |-> sel_in_range)
    else $error("ag_tcu_pe_arb: req_pe_sel out of range");

  for (genvar g = 0; g < PE_COUNT; g++) begin : g_underflow
    credit_underflow_a: assert property (@(posedge clk) disable iff (!reset)
      pe_rsp_valid[g] |-> (credit[g] != '0))
      else $error("ag_tcu_pe_arb: response from PE %0d with no credit", g);
  end

endmodule

// File: tb/tb_ag_tcu_pe_arb.sv
// Directed bench for ag_tcu_pe_arb: issue/retire ordering, credit and FIFO limits,
// downstream backpressure and asynchronous reset.
module tb_ag_tcu_pe_arb;

  localparam int PE_COUNT = 2;
  localparam int DATAW    = 64;
  localparam int TAG_W    = 8;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      req_valid;
  logic                      req_ready;
  logic [0:0]                req_pe_sel;
  logic [TAG_W-1:0]          req_tag;
  logic [PE_COUNT-1:0]       pe_req_valid;
  logic [PE_COUNT-1:0]       pe_req_ready;
  logic [TAG_W-1:0]          pe_req_tag;
  logic [PE_COUNT-1:0]       pe_rsp_valid;
  logic [PE_COUNT-1:0]       pe_rsp_ready;
  logic [PE_COUNT*TAG_W-1:0] pe_rsp_tag;
  logic [PE_COUNT*DATAW-1:0] pe_rsp_data;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [TAG_W-1:0]          rsp_tag;
  logic [DATAW-1:0]          rsp_data;
  logic [0:0]                rsp_pe;
  logic                      busy;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];   // {pe, tag} in issue order

  ag_tcu_pe_arb dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_pe_sel   (req_pe_sel),
    .req_tag      (req_tag),
    .pe_req_valid (pe_req_valid),
    .pe_req_ready (pe_req_ready),
    .pe_req_tag   (pe_req_tag),
    .pe_rsp_valid (pe_rsp_valid),
    .pe_rsp_ready (pe_rsp_ready),
    .pe_rsp_tag   (pe_rsp_tag),
    .pe_rsp_data  (pe_rsp_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_tag      (rsp_tag),
    .rsp_data     (rsp_data),
    .rsp_pe       (rsp_pe),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] data_of(input int pe, input logic [7:0] tag);
    return {40'hDA7A_00_0000, 8'(pe), 8'h00, tag};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rsp(input int pe, input logic v, input logic [7:0] tag);
    pe_rsp_valid[pe]           = v;
    pe_rsp_tag[pe*TAG_W +: TAG_W] = tag;
    pe_rsp_data[pe*DATAW +: DATAW] = v ? data_of(pe, tag) : 64'h0;
  endtask

  task automatic issue(input int pe, input logic [7:0] tag);
    req_valid  = 1'b1;
    req_pe_sel = pe[0:0];
    req_tag    = tag;
    #1;
    check("issue_ready", req_ready, 1);
    check("issue_onehot", pe_req_valid, 64'(1 << pe));
    check("issue_tag", pe_req_tag, tag);
    exp_q.push_back({pe[0], tag});
    tick();
    req_valid = 1'b0;
  endtask

  task automatic retire_check();
    logic [8:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
    check("retire_valid", rsp_valid, 1);
    check("retire_tag", rsp_tag, e[7:0]);
    check("retire_pe", rsp_pe, e[8]);
    check("retire_data", rsp_data, data_of(int'(e[8]), e[7:0]));
  endtask

  task automatic respond(input int pe, input logic [7:0] tag);
    int n;
    n = 0;
    set_rsp(pe, 1'b1, tag);
    #1;
    while (!pe_rsp_ready[pe] && n < 20) begin
      tick();
      n++;
    end
    check("rsp_wait_bound", n < 20, 1);
    tick();
    set_rsp(pe, 1'b0, 8'h00);
    #1;
    retire_check();
  endtask

  initial begin
    reset        = 1'b0;
    req_valid    = 1'b0;
    req_pe_sel   = '0;
    req_tag      = '0;
    pe_req_ready = 2'b11;
    pe_rsp_valid = '0;
    pe_rsp_tag   = '0;
    pe_rsp_data  = '0;
    rsp_ready    = 1'b1;

    // Reset state
    #3;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_tag", rsp_tag, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_pe", rsp_pe, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("idle_pe_rsp_ready", pe_rsp_ready, 0);

    // Single FP request
    issue(0, 8'h11);
    check("single_busy", busy, 1);
    check("single_rsp_rdy", pe_rsp_ready, 2'b01);
    tick();
    tick();
    respond(0, 8'h11);
    check("single_busy_hold", busy, 1);
    tick();
    check("single_rsp_clear", rsp_valid, 0);
    check("single_busy_drop", busy, 0);

    // Reordering: PE1 answers first but must wait for PE0
    issue(0, 8'h01);
    issue(1, 8'h02);
    set_rsp(1, 1'b1, 8'h02);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("order_pe1_blocked", pe_rsp_ready, 2'b01);
      check("order_no_rsp", rsp_valid, 0);
      tick();
    end
    set_rsp(0, 1'b1, 8'h01);
    #1;
    check("order_pe0_rdy", pe_rsp_ready, 2'b01);
    tick();
    set_rsp(0, 1'b0, 8'h00);
    #1;
    retire_check();
    check("order_pe1_rdy", pe_rsp_ready, 2'b10);
    tick();
    set_rsp(1, 1'b0, 8'h00);
    #1;
    retire_check();
    tick();
    check("order_drain_valid", rsp_valid, 0);
    check("order_drain_busy", busy, 0);

    // Credit limit on PE1
    for (int k = 0; k < 4; k++) issue(1, 8'(8'h21 + k));
    req_valid  = 1'b1;
    req_pe_sel = 1'b1;
    req_tag    = 8'h25;
    #1;
    check("cred_block_ready", req_ready, 0);
    check("cred_block_pe_valid", pe_req_valid, 0);
    set_rsp(1, 1'b1, 8'h21);
    #1;
    check("cred_rsp_rdy", pe_rsp_ready, 2'b10);
    tick();
    set_rsp(1, 1'b0, 8'h00);
    #1;
    retire_check();
    check("cred_freed_ready", req_ready, 1);
    check("cred_freed_pe_valid", pe_req_valid, 2'b10);
    exp_q.push_back({1'b1, 8'h25});
    tick();
    req_valid = 1'b0;
    for (int k = 1; k < 5; k++) respond(1, 8'(8'h21 + k));
    tick();
    check("cred_drain_busy", busy, 0);

    // Order FIFO full
    for (int k = 0; k < 8; k++) issue(k % 2, 8'(8'h40 + k));
    req_valid  = 1'b1;
    req_pe_sel = 1'b0;
    req_tag    = 8'h48;
    #1;
    check("full_block_ready", req_ready, 0);
    check("full_block_pe_valid", pe_req_valid, 0);
    tick();
    check("full_still_blocked", req_ready, 0);
    req_valid = 1'b0;
    for (int k = 0; k < 8; k++) respond(k % 2, 8'(8'h40 + k));
    tick();
    check("full_drain_busy", busy, 0);

    // Downstream backpressure
    issue(0, 8'h51);
    issue(1, 8'h52);
    issue(0, 8'h53);
    rsp_ready = 1'b0;
    set_rsp(0, 1'b1, 8'h51);
    set_rsp(1, 1'b1, 8'h52);
    #1;
    check("bp_first_rdy", pe_rsp_ready, 2'b01);
    tick();
    set_rsp(0, 1'b1, 8'h53);
    #1;
    retire_check();
    for (int k = 0; k < 5; k++) begin
      check("bp_pe_rdy_low", pe_rsp_ready, 0);
      check("bp_valid_hold", rsp_valid, 1);
      check("bp_tag_hold", rsp_tag, 8'h51);
      check("bp_data_hold", rsp_data, data_of(0, 8'h51));
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_rdy", pe_rsp_ready, 2'b10);
    tick();
    set_rsp(1, 1'b0, 8'h00);
    #1;
    retire_check();
    check("bp_next_rdy", pe_rsp_ready, 2'b01);
    tick();
    set_rsp(0, 1'b0, 8'h00);
    #1;
    retire_check();
    tick();
    check("bp_drain_valid", rsp_valid, 0);
    check("bp_drain_busy", busy, 0);

    // Asynchronous reset mid-stream
    issue(0, 8'h61);
    issue(1, 8'h62);
    issue(0, 8'h63);
    issue(1, 8'h64);
    rsp_ready = 1'b0;
    set_rsp(0, 1'b1, 8'h61);
    #1;
    tick();
    set_rsp(0, 1'b0, 8'h00);
    #1;
    retire_check();
    check("arst_busy_before", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_rsp_tag", rsp_tag, 0);
    check("arst_rsp_data", rsp_data, 0);
    check("arst_pe_rsp_ready", pe_rsp_ready, 0);
    exp_q.delete();
    rsp_ready = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    issue(0, 8'h33);
    respond(0, 8'h33);
    tick();
    check("arst_final_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
